// File: rtl/scanner_pkg.sv
// Shared definitions for the register-file scanner and the datapath it sits beside.
package scanner_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int ZR_IDX     = 31;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND
    } scan_state_t;

endpackage

// File: rtl/regfile_scanner.sv
// Sequential read-out engine: walks an inclusive, wrapping register range on one
// spare asynchronous read port and streams {index, data} beats over valid/ready.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; range latched when start is accepted
// FETCH | first word of the range is read and captured into the beat
// SEND  | beat presented; each handshake captures the next word or ends
module regfile_scanner
    import scanner_pkg::*;
#(
    parameter int N    = 64,
    parameter int REGS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [REG_ADDR_W-1:0] first,
    input  logic [REG_ADDR_W-1:0] last,
    output logic [REG_ADDR_W-1:0] ra,
    input  logic [N-1:0]          rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_idx,
    output logic [N-1:0]          out_data,
    output logic                  busy,
    output logic                  done
);

    scan_state_t           state;
    logic [REG_ADDR_W-1:0] ptr;
    logic [REG_ADDR_W-1:0] last_q;
    logic                  lastsent;
    logic [REG_ADDR_W-1:0] ptr_nxt;

    // The read port always looks at the pointer; the register file answers combinationally.
    assign ra = ptr;

    // Pointer advance wraps from the top register back to 0.
    assign ptr_nxt = (ptr == REG_ADDR_W'(REGS - 1)) ? '0 : ptr + REG_ADDR_W'(1);

    // Scan FSM with all outputs registered; a capture happens in FETCH and on each non-final handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            last_q    <= '0;
            lastsent  <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr      <= first;
                        last_q   <= last;
                        lastsent <= 1'b0;
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    out_data  <= rd;
                    out_idx   <= ptr;
                    ptr       <= ptr_nxt;
                    lastsent  <= (ptr == last_q);
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        if (!lastsent) begin
                            out_data <= rd;
                            out_idx  <= ptr;
                            ptr      <= ptr_nxt;
                            lastsent <= (ptr == last_q);
                        end else begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_scanner.sv
// Self-checking bench: behavioural register file, range-based expectation queue,
// and an independent monitor that checks every accepted beat, payload hold and done.
module tb_regfile_scanner;
    import scanner_pkg::*;

    localparam int N    = 64;
    localparam int REGS = 32;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [REG_ADDR_W-1:0] first;
    logic [REG_ADDR_W-1:0] last;
    logic [REG_ADDR_W-1:0] ra;
    logic [N-1:0]          rd;
    logic                  out_valid;
    logic                  out_ready;
    logic [REG_ADDR_W-1:0] out_idx;
    logic [N-1:0]          out_data;
    logic                  busy;
    logic                  done;

    logic [N-1:0] rf [REGS];

    always #5 clk = ~clk;

    // Behavioural register file read port; X31 is hardwired to zero.
    assign rd = (ra == REG_ADDR_W'(ZR_IDX)) ? '0 : rf[ra];

    regfile_scanner #(.N(N), .REGS(REGS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .first     (first),
        .last      (last),
        .ra        (ra),
        .rd        (rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [REG_ADDR_W-1:0] idx;
        logic [N-1:0]          data;
        bit                    last;
    } beat_t;

    beat_t sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per accepted beat, checks hold-while-stalled and done timing.
    bit                    done_due = 0;
    bit                    hold     = 0;
    logic [REG_ADDR_W-1:0] h_idx;
    logic [N-1:0]          h_data;
    always @(negedge clk) begin
        beat_t b;
        if (reset) begin
            done_due = 0;
            hold     = 0;
        end else begin
            if (done_due) begin
                check("done_pulse", done, 1);
                check("busy_at_done", busy, 0);
                done_due = 0;
            end else if (done) begin
                check("spurious_done", done, 0);
            end
            if (hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_idx", out_idx, h_idx);
                check("hold_data", out_data, h_data);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got idx=%0d data=%h expected no beat", out_idx, out_data);
                end else begin
                    b = sb.pop_front();
                    check("beat_idx", out_idx, b.idx);
                    check("beat_data", out_data, b.data);
                    if (b.last) done_due = 1;
                end
            end
            hold   = out_valid && !out_ready;
            h_idx  = out_idx;
            h_data = out_data;
        end
    end

    function automatic logic [N-1:0] model_read(input int r);
        return (r == ZR_IDX) ? '0 : rf[r];
    endfunction

    // mode 0: ready always high, 1: random ready, 2: fixed backpressure pattern
    task automatic run_scan(input int f, input int l, input int mode,
                            input bit poke_start, input bit do_write);
        int          nb;
        int          n;
        int          busy_cnt;
        bit          got;
        beat_t       b;
        logic [N-1:0] wval;
        bit          pat [8];
        pat  = '{1, 0, 0, 1, 0, 1, 1, 1};
        wval = 64'hDEAD;
        nb   = ((l - f + 32) % 32) + 1;
        for (int i = 0; i < nb; i++) begin
            b.idx  = REG_ADDR_W'((f + i) % 32);
            b.data = (do_write && ((f + i) % 32) == 7) ? wval : model_read((f + i) % 32);
            b.last = (i == nb - 1);
            sb.push_back(b);
        end
        first     = REG_ADDR_W'(f);
        last      = REG_ADDR_W'(l);
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        first    = REG_ADDR_W'($urandom);
        last     = REG_ADDR_W'($urandom);
        n        = 0;
        busy_cnt = 0;
        got      = 0;
        while (n < 400) begin
            if (done) begin
                got = 1;
                break;
            end
            if (busy) busy_cnt++;
            if (mode == 0 && n == 0) begin
                check("fetch_busy", busy, 1);
                check("fetch_no_valid", out_valid, 0);
            end
            if (mode == 0 && n == 1) check("first_valid", out_valid, 1);
            start = (poke_start && n == 4);
            if (do_write && n == 3) rf[7] = wval;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = (n >= 1 && n <= 8) ? pat[n-1] : 1'b1;
            endcase
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scan_timeout: got no done after %0d cycles expected done", n);
        end else if (mode == 0) begin
            check("done_latency", n, nb + 1);
            check("busy_cycles", busy_cnt, nb + 1);
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        first     = '0;
        last      = '0;
        out_ready = 1'b0;
        for (int i = 0; i < REGS; i++) rf[i] = (i == ZR_IDX) ? '0 : N'(i);
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", out_idx, 0);
        check("rst_data", out_data, 0);
        check("rst_ra", ra, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_scan(0, 31, 0, 0, 0);
        run_scan(30, 1, 0, 0, 0);
        run_scan(5, 5, 0, 0, 0);
        run_scan(2, 6, 2, 0, 0);
        run_scan(0, 10, 0, 0, 1);
        run_scan(0, 15, 0, 1, 0);

        // Abort at the third beat; the pending beats must vanish without done.
        for (int i = 0; i < 21; i++) begin
            beat_t b;
            b.idx  = REG_ADDR_W'(i);
            b.data = model_read(i);
            b.last = (i == 20);
            sb.push_back(b);
        end
        first     = 5'd0;
        last      = 5'd20;
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre_reset_idx", out_idx, 2);
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_ra", ra, 0);
        check("abort_done", done, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        run_scan(3, 9, 0, 0, 0);

        for (int s = 0; s < 25; s++) begin
            if (s % 5 == 0)
                for (int i = 0; i < REGS; i++) rf[i] = {$urandom, $urandom};
            run_scan($urandom_range(0, 31), $urandom_range(0, 31), 1, (s % 3 == 0), 0);
        end

        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_scanner.md
# regfile_scanner

Sequential read-out engine for the 32-entry, 64-bit register file in the single-cycle processor. On a start pulse it walks an inclusive register range `first..last`, wrapping at 31→0 when needed. For each register it drives the register file's asynchronous read address, captures the returned data and streams `{index, data}` beats over a valid/ready handshake. It sits beside the datapath on one spare read port and feeds debug/trace logic and the testbench dump path.

## Interface
- `N`, 64, data width; matches the register file word.
- `REGS`, 32, number of architectural registers; the address width is log2(REGS) = 5.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  scan request; sampled only in IDLE.
- `first`  in  5  first register index; latched on an accepted `start`.
- `last`  in  5  last register index, inclusive; latched on an accepted `start`.
- `ra`  out  5  register file read address, combinational from the internal pointer.
- `rd`  in  N  register file read data; combinational response to `ra`.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  consumer accepts the beat.
- `out_idx`  out  5  register index of the current beat.
- `out_data`  out  N  register value of the current beat.
- `busy`  out  1  high in FETCH and SEND.
- `done`  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- The FSM has three states: IDLE, FETCH and SEND.
- **IDLE:** on `start`=1, latch `ptr<=first`, `last_q<=last` and `lastsent<=0`, then go to FETCH.
- **FETCH:** capture `out_data<=rd`, `out_idx<=ptr` and `ptr<=ptr+1` (mod 32). Set `lastsent<=(ptr==last_q)`, then go to SEND.
- **SEND:** `out_valid`=1.
  - On `out_valid & out_ready` with `lastsent`=0: capture the next word exactly as FETCH does and stay in SEND.
  - On a handshake with `lastsent`=1: go to IDLE and pulse `done`.
  - Without a handshake, `out_idx` and `out_data` hold stable.
- `ra` always equals `ptr`. The data captured is whatever `rd` returns in the capture cycle, so a same-cycle register write is not visible; a write committed on an earlier edge is.
- Beat count is `((last-first) mod 32)+1`. `first==last` gives 1 beat. `first=last+1` (mod 32) gives all 32 beats. `first>last` wraps through 31→0.
- `start` is ignored while busy; there is no queueing.
- `ptr` arithmetic is 5-bit and wraps naturally; there is no overflow flag.
- X31 reads return whatever the register file returns (0); the scanner does not special-case it.

## Timing
- Reset values:
  - State is IDLE.
  - `out_valid`, `busy` and `done` are 0.
  - `out_idx` and `out_data` are 0.
  - `ptr` is 0, so `ra` is 0.
- Reset mid-scan aborts: the next cycle shows IDLE with all outputs at their reset values. The pending beat is dropped and `done` is not asserted.
- Latency: `start` at edge k is followed by FETCH in cycle k+1, with `out_valid`=1 from cycle k+2.
- Throughput: 1 beat/cycle with `out_ready` held high.
- Full 32-register scan with `ready`=1: last beat in cycle k+33; `done`=1 in cycle k+34 with `busy`=0.
- `done` is coincident with the first IDLE cycle. A `start` in that same cycle is accepted.
- `out_valid` never drops without a handshake, and the payload never changes while valid and not ready.

## Structure
- Shared package `scanner_pkg` holds:
  - the state enum `scan_state_t` (IDLE, FETCH, SEND);
  - the constant `REG_ADDR_W`=5;
  - the constant `ZR_IDX`=31 (shared with the datapath).
- Single module; no sub-module. The pointer/capture logic is small enough to stay inline with the FSM.

## Test plan
Benches instantiate the scanner against the real register file, initialised with Xi=i and X31=0.

- **Full scan:** `first`=0, `last`=31, `ready`=1 → 32 beats, idx 0..31, data=idx except idx 31 data=0. `done` is 1 cycle after the final beat, 34 cycles after `start`.
- **Wrap:** `first`=30, `last`=1 → idx 30,31,0,1 with data 30,0,0,1, then `done`.
- **Single:** `first`=`last`=5 → exactly one beat (5, 5). `done` follows the handshake; `busy` is high for 2 cycles.
- **Backpressure:** `first`=2, `last`=6, `ready` pattern 1,0,0,1,0,1,1,1… → beats 2..6 in order, with no duplicate or loss. The payload is stable during every valid & !ready cycle.
- **Write during scan:** write X7=0xDEAD committed before the capture of idx 7, in a 0..10 scan → beat 7 data=0xDEAD, others=idx.
- **Control corner cases:**
  - `start` pulsed during a scan → ignored; the original range completes.
  - `reset` asserted at the 3rd beat → next cycle `out_valid`=0, `busy`=0, `ra`=0, with no `done`.
  - A fresh scan after the reset runs correctly.
